// File: rtl/atmega_pp_sequencer.sv
// rtl/atmega_pp_sequencer.sv - ATmega parallel-programming pin sequencer, one command per handshake.
// Optional feature: define ATMEGA_PP_RDY_TIMEOUT_EN to bound the RDY wait by RDY_TIMEOUT clocks.
module atmega_pp_sequencer #(
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int RDY_MASK_CYC = 4
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
    ,
    parameter int RDY_TIMEOUT  = 65535
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] dut_data_o,
    output logic       dut_data_oe,
    input  logic [7:0] dut_data_i,
    input  logic       dut_rdy,
    output logic       dut_oe_n,
    output logic       dut_wr_n,
    output logic       dut_xtal,
    output logic       dut_pagel,
    output logic       dut_bs1,
    output logic       dut_bs2,
    output logic       dut_xa0,
    output logic       dut_xa1
);

    localparam logic [2:0] OP_LD_CMD = 3'd0;
    localparam logic [2:0] OP_LD_AHI = 3'd2;
    localparam logic [2:0] OP_LD_DLO = 3'd3;
    localparam logic [2:0] OP_LD_DHI = 3'd4;
    localparam logic [2:0] OP_WRITE  = 3'd5;
    localparam logic [2:0] OP_READ   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] MASK_LAST  = 16'(RDY_MASK_CYC - 1);
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST  = 16'(RDY_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_MASK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  arg_q, arg_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        active;
    logic        is_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            op_q    <= 3'd0;
            arg_q   <= 8'd0;
            rdata_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // cnt_q counts clocks spent in the current phase and restarts on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        op_d    = op_q;
        arg_d   = arg_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    arg_d   = cmd_arg;
                    rdata_d = 8'd0;
                    err_d   = (cmd_op == OP_RSVD);
                    state_d = (cmd_op == OP_RSVD) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = 16'd0;
                end
            end
            S_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    if (op_q == OP_READ) begin
                        rdata_d = dut_data_i;
                    end
                    state_d = S_HOLD;
                    cnt_d   = 16'd0;
                end
            end
            S_HOLD: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = (op_q == OP_WRITE) ? S_MASK : S_DONE;
                    cnt_d   = 16'd0;
                end
            end
            S_MASK: begin
                if (cnt_q == MASK_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd0;
                end
            end
            S_WAIT: begin
                if (dut_rdy) begin
                    state_d = S_DONE;
                end
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
                else if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    assign active  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD) ||
                     (state_q == S_MASK)  || (state_q == S_WAIT);
    assign is_load = (op_q <= OP_LD_DHI);

    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = 8'd0;
        dut_data_o  = 8'd0;
        dut_data_oe = 1'b0;
        dut_oe_n    = 1'b1;
        dut_wr_n    = 1'b1;
        dut_xtal    = 1'b0;
        dut_pagel   = 1'b0;
        dut_bs1     = 1'b0;
        dut_bs2     = 1'b0;
        dut_xa0     = 1'b0;
        dut_xa1     = 1'b0;
        if (state_q == S_DONE) begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_data  = rdata_q;
        end else if (active) begin
            dut_xa1 = (op_q == OP_LD_CMD);
            dut_xa0 = (op_q == OP_LD_DLO) || (op_q == OP_LD_DHI);
            if (is_load) begin
                dut_bs1     = (op_q == OP_LD_AHI) || (op_q == OP_LD_DHI);
                dut_data_oe = 1'b1;
                dut_data_o  = arg_q;
                dut_xtal    = (state_q == S_STROBE);
                // PAGEL follows the XTAL pulse, riding the hold phase while data is still driven.
                dut_pagel   = (op_q == OP_LD_DHI) && (state_q == S_HOLD);
            end else begin
                dut_bs1  = arg_q[0];
                dut_bs2  = arg_q[1];
                dut_wr_n = !((op_q == OP_WRITE) && (state_q == S_STROBE));
                dut_oe_n = !((op_q == OP_READ) &&
                             ((state_q == S_SETUP) || (state_q == S_STROBE)));
            end
        end
    end

endmodule

// File: tb/tb_atmega_pp_sequencer.sv
// tb/tb_atmega_pp_sequencer.sv - self-checking bench for atmega_pp_sequencer against a timeline model.
module tb_atmega_pp_sequencer;

    localparam int S = 2;
    localparam int P = 4;
    localparam int M = 4;
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
    localparam int T = 100;
`endif

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] dut_data_o;
    logic       dut_data_oe;
    logic [7:0] dut_data_i;
    logic       dut_rdy;
    logic       dut_oe_n;
    logic       dut_wr_n;
    logic       dut_xtal;
    logic       dut_pagel;
    logic       dut_bs1;
    logic       dut_bs2;
    logic       dut_xa0;
    logic       dut_xa1;

    int total = 0;
    int bad   = 0;

    atmega_pp_sequencer #(
        .SETUP_CYC   (S),
        .PULSE_CYC   (P),
        .RDY_MASK_CYC(M)
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
        ,
        .RDY_TIMEOUT (T)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .dut_data_o (dut_data_o),
        .dut_data_oe(dut_data_oe),
        .dut_data_i (dut_data_i),
        .dut_rdy    (dut_rdy),
        .dut_oe_n   (dut_oe_n),
        .dut_wr_n   (dut_wr_n),
        .dut_xtal   (dut_xtal),
        .dut_pagel  (dut_pagel),
        .dut_bs1    (dut_bs1),
        .dut_bs2    (dut_bs2),
        .dut_xa0    (dut_xa0),
        .dut_xa1    (dut_xa1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {ready, data_oe, data_o, oe_n, wr_n, xtal, pagel, bs1, bs2, xa0, xa1, rsp_valid, rsp_err, rsp_data}
    function automatic logic [27:0] pack(input bit rdy, input bit doe, input logic [7:0] dout,
                                         input bit oen, input bit wrn, input bit xtal,
                                         input bit pagel, input bit bs1, input bit bs2,
                                         input bit xa0, input bit xa1, input bit rv,
                                         input bit re, input logic [7:0] rd);
        return {rdy, doe, dout, oen, wrn, xtal, pagel, bs1, bs2, xa0, xa1, rv, re, rd};
    endfunction

    function automatic logic [27:0] idle_vec();
        return pack(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endfunction

    function automatic logic [27:0] observed();
        return {cmd_ready, dut_data_oe, dut_data_o, dut_oe_n, dut_wr_n, dut_xtal, dut_pagel,
                dut_bs1, dut_bs2, dut_xa0, dut_xa1, rsp_valid, rsp_err, rsp_data};
    endfunction

    // Expected pins at clock k after acceptance, derived from the op timeline rules.
    function automatic logic [27:0] model(input int op, input logic [7:0] arg, input int k,
                                          input int done, input bit err, input logic [7:0] rd);
        bit load;
        load = (op <= 4);
        if (k > done) return idle_vec();
        if (k == done) return pack(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 1, err,
                                   (op == 6) ? rd : 8'h00);
        return pack(0, load, load ? arg : 8'h00,
                    !(op == 6 && k <= S + P),
                    !(op == 5 && k > S && k <= S + P),
                    load && k > S && k <= S + P,
                    op == 4 && k > S + P && k <= 2 * S + P,
                    load ? (op == 2 || op == 4) : arg[0],
                    (op == 5 || op == 6) && arg[1],
                    op == 3 || op == 4,
                    op == 0,
                    0, 0, 8'h00);
    endfunction

    function automatic bit rdy_at(input int k, input int r, input bit glitch);
        return (k >= r) || (glitch && k >= 2 * S + P + 1 && k <= 2 * S + P + 2);
    endfunction

    task automatic check(input string tag, input int k, input logic [27:0] exp);
        logic [27:0] obs;
        obs = observed();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Issues one command from an idle negedge and checks every clock up to the idle after DONE.
    task automatic run_cmd(input string tag, input int op, input logic [7:0] arg, input int r,
                           input bit glitch, input int abort_k, input int din_fix);
        int         done;
        int         w0;
        bit         err;
        logic [7:0] rd;
        logic [7:0] din;
        rd   = 8'h00;
        done = 0;
        err  = 0;
        if (op == 7) begin
            done = 1;
            err  = 1;
        end else if (op != 5) begin
            done = 2 * S + P + 1;
        end else begin
            w0 = 2 * S + P + M + 1;
            for (int k = w0; k < w0 + 5000; k++) begin
                if (rdy_at(k, r, glitch)) begin
                    done = k + 1;
                    break;
                end
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
                if (k == w0 + T - 1) begin
                    done = k + 1;
                    err  = 1;
                    break;
                end
`endif
            end
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_arg   = arg;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_arg   = 8'($urandom);
        for (int k = 1; k <= done; k++) begin
            check(tag, k, model(op, arg, k, done, err, rd));
            if (k == abort_k) begin
                rst_n = 1'b0;
                @(negedge clk);
                check({tag, "_rst"}, k + 1, idle_vec());
                rst_n = 1'b1;
                @(negedge clk);
                break;
            end
            dut_rdy    = (op == 5) ? rdy_at(k, r, glitch) : 1'($urandom);
            din        = (din_fix >= 0) ? 8'(din_fix) : 8'($urandom);
            dut_data_i = din;
            if (k == S + P) rd = din;
            @(negedge clk);
        end
        check({tag, "_idle"}, done + 1, idle_vec());
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_arg    = 8'h00;
        dut_data_i = 8'h00;
        dut_rdy    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hold", 0, idle_vec());
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", 0, idle_vec());

        run_cmd("ld_cmd_80", 0, 8'h80, 0, 0, 0, -1);
        run_cmd("ld_dhi_5a", 4, 8'h5A, 0, 0, 0, -1);
        run_cmd("write_rdy20", 5, 8'h00, 2 * S + P + M + 1 + 20, 0, 0, -1);
        run_cmd("write_glitch", 5, 8'h03, 2 * S + P + M + 5, 1, 0, -1);
        run_cmd("read_c3", 6, 8'h01, 0, 0, 0, 8'hC3);
        run_cmd("op7", 7, 8'hFF, 0, 0, 0, -1);
        run_cmd("ld_alo", 1, 8'h12, 0, 0, 0, -1);
        run_cmd("abort_strobe", 0, 8'h33, 0, 0, 4, -1);
        run_cmd("after_abort", 3, 8'hA5, 0, 0, 0, -1);
`ifdef ATMEGA_PP_RDY_TIMEOUT_EN
        run_cmd("wr_timeout", 5, 8'h00, 1000000, 0, 0, -1);
        run_cmd("op7_to", 7, 8'h00, 0, 0, 0, -1);
`endif
        for (int i = 0; i < 40; i++) begin
            run_cmd("rand", int'($urandom_range(0, 7)), 8'($urandom),
                    int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
